spi_xfer_engine: RTL and testbench

SPI master transfer engine that initiates transactions on both data FIFOs of the SPI IP core.
- TX side: it is the reader of the TX FIFO. It pulls one word through the FIFO read-port handshake (req/resp/ack) and shifts that word out on MOSI.
- RX side: it is the writer of the RX FIFO. It captures MISO into a word and pushes it through the FIFO write-port handshake (req/ack).
- It sits between the TX/RX FIFOs and the SPI pads, in the same clock domain as the FIFOs.

---
 rtl/spi_xfer_engine.sv | 192 +++++++++++++++++++
 tb/tb_spi_xfer_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_engine.sv
// SPI master transfer engine: pulls one word from the TX FIFO, shifts it out on MOSI
// while capturing MISO, then pushes the captured word into the RX FIFO.
module spi_xfer_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  soft_rst_i,
  input  logic                  enable_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  tx_empty_i,
  output logic                  tx_req_o,
  input  logic                  tx_resp_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ack_o,
  output logic                  rx_req_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_ack_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_REQ,
    TX_WAIT,
    TX_ACK,
    TX_REL,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    RX_PUSH
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [DIV_WIDTH-1:0]  div_cfg_q;
  logic [DIV_WIDTH-1:0]  div_cnt_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic [EDGE_W-1:0]     edge_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic                  sclk_q;

  logic hp_end;
  logic last_edge;
  logic sample_edge;
  logic drive_edge;
  logic start_word;
  logic in_frame;

  assign hp_end      = (div_cnt_q == '0);
  assign last_edge   = (edge_cnt_q == LAST_EDGE);
  // Even edge indices are leading edges; the MSB is already on MOSI before edge 0.
  assign sample_edge = cpha_q ? edge_cnt_q[0] : ~edge_cnt_q[0];
  assign drive_edge  = ~sample_edge && (edge_cnt_q != '0);
  assign start_word  = enable_i && !tx_empty_i && !tx_resp_i;
  assign in_frame    = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD);

  assign sclk_o = (state_q == IDLE) ? cpol_i : sclk_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_word) state_d = TX_REQ;
      TX_REQ:   state_d = TX_WAIT;
      TX_WAIT:  if (tx_resp_i) state_d = TX_ACK;
      TX_ACK:   state_d = TX_REL;
      TX_REL:   if (!tx_resp_i) state_d = CS_SETUP;
      CS_SETUP: if (hp_end) state_d = SHIFT;
      SHIFT:    if (hp_end && last_edge) state_d = CS_HOLD;
      CS_HOLD:  if (hp_end) state_d = RX_PUSH;
      RX_PUSH:  if (rx_ack_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (soft_rst_i) begin
      state_d = IDLE;
    end
  end

  // Handshake and framing outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tx_req_o <= 1'b0;
      tx_ack_o <= 1'b0;
      rx_req_o <= 1'b0;
      cs_n_o   <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      tx_req_o <= (state_d == TX_REQ);
      tx_ack_o <= (state_d == TX_ACK);
      rx_req_o <= (state_d == RX_PUSH);
      cs_n_o   <= !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
      busy_o   <= (state_d != IDLE);
      done_o   <= (state_q == RX_PUSH) && rx_ack_i && !soft_rst_i;
    end
  end

  // Mode and divider are frozen once a word leaves IDLE.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_cfg_q <= '0;
    end else if (state_q == IDLE) begin
      cpol_q    <= cpol_i;
      cpha_q    <= cpha_i;
      div_cfg_q <= clk_div_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      sclk_q     <= 1'b0;
      mosi_o     <= 1'b0;
      rx_data_o  <= '0;
    end else if (soft_rst_i) begin
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= cpol_i;
      mosi_o     <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      if (in_frame) begin
        div_cnt_q <= hp_end ? div_cfg_q : div_cnt_q - 1'b1;
      end
      case (state_q)
        IDLE: begin
          sclk_q <= cpol_i;
        end
        TX_WAIT: begin
          if (tx_resp_i) begin
            tx_shift_q <= tx_data_i;
          end
        end
        TX_REL: begin
          if (!tx_resp_i) begin
            div_cnt_q  <= div_cfg_q;
            edge_cnt_q <= '0;
            sclk_q     <= cpol_q;
            mosi_o     <= tx_shift_q[DATA_WIDTH-1];
          end
        end
        SHIFT: begin
          if (hp_end) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= last_edge ? '0 : edge_cnt_q + 1'b1;
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], miso_i};
            end
            if (drive_edge) begin
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              mosi_o     <= tx_shift_q[DATA_WIDTH-2];
            end
          end
        end
        CS_HOLD: begin
          if (hp_end) begin
            rx_data_o <= rx_shift_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine with 8-bit words, a TX/RX FIFO responder and an SPI slave model.
module tb_spi_xfer_engine;

  localparam int DW   = 8;
  localparam int DIVW = 8;

  logic            clk_i = 1'b0;
  logic            arst_n_i = 1'b1;
  logic            soft_rst_i = 1'b0;
  logic            enable_i = 1'b0;
  logic            cpol_i = 1'b1;
  logic            cpha_i = 1'b0;
  logic [DIVW-1:0] clk_div_i = '0;
  logic            tx_empty_i;
  logic            tx_req_o;
  logic            tx_resp_i = 1'b0;
  logic [DW-1:0]   tx_data_i = '0;
  logic            tx_ack_o;
  logic            rx_req_o;
  logic [DW-1:0]   rx_data_o;
  logic            rx_ack_i = 1'b0;
  logic            sclk_o;
  logic            mosi_o;
  logic            miso_i;
  logic            cs_n_o;
  logic            busy_o;
  logic            done_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] tx_mem [0:31];
  int            tx_wr = 0;
  int            tx_rd = 0;
  logic [DW-1:0] rx_log [0:31];
  int            rx_cnt = 0;
  int            rx_wait = 0;
  int            rx_delay = 0;
  int            last_hold = 0;
  int            tx_reqs = 0;
  int            tx_acks = 0;
  int            dones = 0;
  int            overlap = 0;
  int            cs_run = 0;
  int            last_cs_low = 0;

  logic          loop_en = 1'b1;
  logic [DW-1:0] slv_pattern = '0;
  logic [DW-1:0] slv_tx = '0;
  logic [DW-1:0] slv_rx = '0;
  int            slv_edges = 0;
  int            slv_samples = 0;
  logic          slv_cs_q = 1'b1;
  logic          slv_sclk_q = 1'b0;
  logic          slv_lead;

  int req0, ack0, done0, rx0, bad, found;

  spi_xfer_engine #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .soft_rst_i (soft_rst_i),
    .enable_i   (enable_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .clk_div_i  (clk_div_i),
    .tx_empty_i (tx_empty_i),
    .tx_req_o   (tx_req_o),
    .tx_resp_i  (tx_resp_i),
    .tx_data_i  (tx_data_i),
    .tx_ack_o   (tx_ack_o),
    .rx_req_o   (rx_req_o),
    .rx_data_o  (rx_data_o),
    .rx_ack_i   (rx_ack_i),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .cs_n_o     (cs_n_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  assign tx_empty_i = (tx_rd == tx_wr);
  assign miso_i     = loop_en ? mosi_o : slv_tx[DW-1];

  // FIFO responders and event counters, all sampled on the falling edge.
  always @(negedge clk_i) begin
    if (!arst_n_i) begin
      tx_resp_i = 1'b0;
      rx_ack_i  = 1'b0;
      rx_wait   = 0;
      cs_run    = 0;
    end else begin
      if (tx_ack_o) begin
        tx_rd++;
        tx_resp_i = 1'b0;
        tx_acks++;
      end else if (tx_req_o) begin
        tx_resp_i = 1'b1;
        tx_data_i = tx_mem[tx_rd];
        tx_reqs++;
      end
      if (rx_ack_i) begin
        rx_ack_i = 1'b0;
      end else if (rx_req_o) begin
        if (rx_wait >= rx_delay) begin
          rx_ack_i       = 1'b1;
          rx_log[rx_cnt] = rx_data_o;
          rx_cnt++;
          last_hold      = rx_wait + 1;
          rx_wait        = 0;
        end else begin
          rx_wait++;
        end
      end
      if (done_o) dones++;
      if (tx_req_o && rx_req_o) overlap++;
      if (cs_n_o === 1'b0) begin
        cs_run++;
      end else if (cs_run != 0) begin
        last_cs_low = cs_run;
        cs_run      = 0;
      end
    end
  end

  // SPI slave: shifts its own pattern out and records MOSI on the edges the mode calls sample edges.
  always @(sclk_o or cs_n_o) begin
    if (cs_n_o === 1'b0 && slv_cs_q !== 1'b0) begin
      slv_tx      = slv_pattern;
      slv_rx      = '0;
      slv_edges   = 0;
      slv_samples = 0;
    end else if (cs_n_o === 1'b0 && sclk_o !== slv_sclk_q) begin
      slv_lead = (sclk_o !== cpol_i);
      if (slv_lead != cpha_i) begin
        slv_rx = {slv_rx[DW-2:0], mosi_o};
        slv_samples++;
      end else if (slv_edges != 0) begin
        slv_tx = {slv_tx[DW-2:0], 1'b0};
      end
      slv_edges++;
    end
    slv_cs_q   = cs_n_o;
    slv_sclk_q = sclk_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word, input logic pol, input logic pha,
                               input logic [DIVW-1:0] div, input logic loop);
    cpol_i         = pol;
    cpha_i         = pha;
    clk_div_i      = div;
    loop_en        = loop;
    tx_mem[tx_wr]  = word;
    tx_wr++;
  endtask

  task automatic waitDones(input int target, input string tag);
    int n = 0;
    while (dones < target && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    checkOutput(tag, (dones >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    #2 arst_n_i = 1'b0;
    #1;
    checkOutput("rst_tx_req", tx_req_o, 0);
    checkOutput("rst_tx_ack", tx_ack_o, 0);
    checkOutput("rst_rx_req", rx_req_o, 0);
    checkOutput("rst_rx_data", rx_data_o, 0);
    checkOutput("rst_mosi", mosi_o, 0);
    checkOutput("rst_cs_n", cs_n_o, 1);
    checkOutput("rst_sclk_cpol1", sclk_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    repeat (3) @(negedge clk_i);
    arst_n_i = 1'b1;
    cpol_i   = 1'b0;
    #1;
    checkOutput("idle_sclk_follows_cpol0", sclk_o, 0);
    enable_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Test 1: mode 0, div 1, loopback, 0xA5
    $display("[TB] test 1: mode 0 loopback");
    req0 = tx_reqs; ack0 = tx_acks; done0 = dones; rx0 = rx_cnt;
    applyStimulus(8'hA5, 1'b0, 1'b0, 8'd1, 1'b1);
    waitDones(done0 + 1, "t1_done_seen");
    checkOutput("t1_tx_req_pulses", tx_reqs - req0, 1);
    checkOutput("t1_tx_ack_pulses", tx_acks - ack0, 1);
    checkOutput("t1_done_pulses", dones - done0, 1);
    checkOutput("t1_cs_low_clks", last_cs_low, 36);
    checkOutput("t1_rising_edges", slv_samples, 8);
    checkOutput("t1_total_edges", slv_edges, 16);
    checkOutput("t1_mosi_at_rise", slv_rx, 8'hA5);
    checkOutput("t1_rx_pushed", rx_log[rx0], 8'hA5);
    checkOutput("t1_rx_data_o", rx_data_o, 8'hA5);
    checkOutput("t1_idle_sclk", sclk_o, 0);

    // Test 2: modes 1..3 against a slave returning 0xC3
    for (int m = 1; m <= 3; m++) begin
      $display("[TB] test 2: mode %0d", m);
      slv_pattern = 8'hC3;
      done0 = dones; rx0 = rx_cnt;
      applyStimulus(8'h3C, m[1], m[0], DIVW'(m - 1), 1'b0);
      waitDones(done0 + 1, "t2_done_seen");
      checkOutput("t2_rx_pushed", rx_log[rx0], 8'hC3);
      checkOutput("t2_slave_saw", slv_rx, 8'h3C);
      checkOutput("t2_samples", slv_samples, 8);
      checkOutput("t2_cs_low_clks", last_cs_low, 18 * m);
      checkOutput("t2_idle_sclk", sclk_o, m[1]);
    end

    // Test 3: three words with a slow RX FIFO
    $display("[TB] test 3: back-pressure");
    rx_delay = 4;
    req0 = tx_reqs; ack0 = tx_acks; done0 = dones; rx0 = rx_cnt;
    applyStimulus(8'h11, 1'b0, 1'b0, 8'd0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b0, 8'd0, 1'b1);
    applyStimulus(8'h33, 1'b0, 1'b0, 8'd0, 1'b1);
    waitDones(done0 + 3, "t3_done_seen");
    checkOutput("t3_push0", rx_log[rx0], 8'h11);
    checkOutput("t3_push1", rx_log[rx0 + 1], 8'h22);
    checkOutput("t3_push2", rx_log[rx0 + 2], 8'h33);
    checkOutput("t3_push_count", rx_cnt - rx0, 3);
    checkOutput("t3_tx_ack_pulses", tx_acks - ack0, 3);
    checkOutput("t3_tx_req_pulses", tx_reqs - req0, 3);
    checkOutput("t3_rx_req_hold", last_hold, 5);
    checkOutput("t3_req_during_push", overlap, 0);
    rx_delay = 0;

    // Test 4: enabled with an empty TX FIFO
    $display("[TB] test 4: empty FIFO");
    req0 = tx_reqs;
    bad  = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (tx_req_o !== 1'b0 || busy_o !== 1'b0 || cs_n_o !== 1'b1) bad++;
    end
    checkOutput("t4_idle_violations", bad, 0);
    checkOutput("t4_tx_req_pulses", tx_reqs - req0, 0);

    // Test 5: soft reset in the middle of bit 3, mode 2
    $display("[TB] test 5: soft reset");
    done0 = dones; rx0 = rx_cnt;
    applyStimulus(8'h96, 1'b1, 1'b0, 8'd1, 1'b1);
    applyStimulus(8'h5A, 1'b1, 1'b0, 8'd1, 1'b1);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (cs_n_o === 1'b0 && slv_edges == 6) begin
        found = 1;
        break;
      end
    end
    checkOutput("t5_reached_bit3", found, 1);
    soft_rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("t5_cs_n", cs_n_o, 1);
    checkOutput("t5_sclk_cpol", sclk_o, 1);
    checkOutput("t5_rx_req", rx_req_o, 0);
    checkOutput("t5_busy", busy_o, 0);
    soft_rst_i = 1'b0;
    waitDones(done0 + 1, "t5_done_seen");
    checkOutput("t5_push_count", rx_cnt - rx0, 1);
    checkOutput("t5_next_word", rx_log[rx0], 8'h5A);

    // Test 6: async reset while TX ack is high
    $display("[TB] test 6: async reset in TX_ACK");
    applyStimulus(8'h77, 1'b0, 1'b0, 8'd1, 1'b1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      #1;
      if (tx_ack_o === 1'b1) begin
        found = 1;
        break;
      end
    end
    checkOutput("t6_ack_reached", found, 1);
    arst_n_i = 1'b0;
    #1;
    checkOutput("t6_tx_ack", tx_ack_o, 0);
    checkOutput("t6_tx_req", tx_req_o, 0);
    checkOutput("t6_rx_req", rx_req_o, 0);
    checkOutput("t6_rx_data", rx_data_o, 0);
    checkOutput("t6_mosi", mosi_o, 0);
    checkOutput("t6_cs_n", cs_n_o, 1);
    checkOutput("t6_sclk", sclk_o, 0);
    checkOutput("t6_busy", busy_o, 0);
    checkOutput("t6_done", done_o, 0);
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    done0 = dones; rx0 = rx_cnt;
    waitDones(done0 + 1, "t6_done_seen");
    checkOutput("t6_word_reread", rx_log[rx0], 8'h77);

    repeat (5) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
